lsu_ctrl: RTL

- Load/store control stage that sits directly upstream of the core's byte-addressed data RAM.
- Accepts one memory request per handshake from execute: base, offset, funct3, store data and destination register.
- Computes the effective address, checks alignment and range, and drives the RAM port signals for exactly one access cycle.
- Captures the RAM's combinational read data and returns one response per request to writeback.

---
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a byte-addressed data RAM: one request
// in, one RAM access cycle, one response out.
module lsu_ctrl #(
    parameter int W           = 32,
    parameter int ADDR_BITS   = 8,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [W-1:0] req_base,
    input  logic [W-1:0] req_offset,
    input  logic [W-1:0] req_wdata,
    input  logic [4:0]   req_rd,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_rdata,
    output logic [4:0]   resp_rd,
    output logic         resp_err,
    output logic [W-1:0] ram_addr,
    output logic [W-1:0] ram_wdat,
    output logic         ram_we,
    output logic         ram_re,
    output logic [3:0]   ram_type,
    output logic         sign,
    input  logic [W-1:0] data_reg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [W:0] RAM_BYTES = (W+1)'(1) << ADDR_BITS;

    logic [1:0]   state_reg;
    logic [2:0]   funct3_reg;
    logic [4:0]   rd_reg;
    logic [W-1:0] eff;
    logic [2:0]   size_bytes;
    logic [3:0]   store_mask;
    logic [3:0]   load_code;
    logic [W:0]   last_byte;
    logic         illegal;
    logic         misaligned;
    logic         out_of_range;
    logic         err;
    logic [W-1:0] load_data;

    assign req_ready = (state_reg == IDLE);
    assign eff       = req_base + req_offset;

    always_comb begin
        size_bytes = 3'd4;
        store_mask = 4'b1111;
        load_code  = 4'b1000;
        case (req_funct3[1:0])
            2'b00: begin
                size_bytes = 3'd1;
                store_mask = 4'b0001;
                load_code  = 4'b0001;
            end
            2'b01: begin
                size_bytes = 3'd2;
                store_mask = 4'b0011;
                load_code  = 4'b0010;
            end
            default: ;
        endcase
    end

    assign illegal = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));

    assign misaligned = ALIGN_CHECK &&
                        (((size_bytes == 3'd2) && eff[0]) ||
                         ((size_bytes == 3'd4) && (eff[1:0] != 2'b00)));

    // One extra bit so a top-of-space access cannot wrap back into range.
    assign last_byte    = {1'b0, eff} + (W+1)'(size_bytes) - (W+1)'(1);
    assign out_of_range = (last_byte >= RAM_BYTES);
    assign err          = illegal || misaligned || out_of_range;

    // RAM returns the addressed data right-aligned; only extension happens here.
    always_comb begin
        load_data = data_reg;
        case (funct3_reg[1:0])
            2'b00:   load_data = {{(W-8){~funct3_reg[2] & data_reg[7]}}, data_reg[7:0]};
            2'b01:   load_data = {{(W-16){~funct3_reg[2] & data_reg[15]}}, data_reg[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            funct3_reg <= '0;
            rd_reg     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
            ram_addr   <= '0;
            ram_wdat   <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            ram_type   <= '0;
            sign       <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            ram_type <= '0;
            sign     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_reg <= req_funct3;
                        rd_reg     <= req_rd;
                        if (err) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            resp_rd    <= req_we ? 5'd0 : req_rd;
                        end else if (req_we) begin
                            state_reg <= WRITE;
                            ram_addr  <= eff;
                            ram_wdat  <= req_wdata;
                            ram_we    <= 1'b1;
                            ram_type  <= store_mask;
                        end else begin
                            state_reg <= READ;
                            ram_addr  <= eff;
                            ram_re    <= 1'b1;
                            ram_type  <= load_code;
                            sign      <= ~req_funct3[2];
                        end
                    end
                end
                WRITE: begin
                    state_reg  <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    resp_rd    <= '0;
                end
                READ: begin
                    state_reg  <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                    resp_rd    <= rd_reg;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg  <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
